// File: rtl/vga_timing_pkg.sv
// Shared VGA timing constants (640x480@60 on a 4x pixel clock) and total-period helpers.
// Used by vga_timing_gen; the optional frame counter is enabled with VGA_FRAME_CNT_EN.
package vga_timing_pkg;

    localparam int unsigned DEF_DIV      = 4;
    localparam int unsigned DEF_H_ACTIVE = 640;
    localparam int unsigned DEF_H_FP     = 16;
    localparam int unsigned DEF_H_SYNC   = 96;
    localparam int unsigned DEF_H_BP     = 48;
    localparam int unsigned DEF_V_ACTIVE = 480;
    localparam int unsigned DEF_V_FP     = 10;
    localparam int unsigned DEF_V_SYNC   = 2;
    localparam int unsigned DEF_V_BP     = 33;

    function automatic int unsigned h_total(input int unsigned active, input int unsigned fp,
                                            input int unsigned sync, input int unsigned bp);
        return active + fp + sync + bp;
    endfunction

    function automatic int unsigned v_total(input int unsigned active, input int unsigned fp,
                                            input int unsigned sync, input int unsigned bp);
        return active + fp + sync + bp;
    endfunction

endpackage

// File: rtl/vga_tick_div.sv
// Clock divider producing the one-cycle pixel strobe; holds while en is low,
// restarts from zero on resync.
module vga_tick_div #(
    parameter int unsigned DIV = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic en,
    input  logic resync,
    output logic p_tick
);

    localparam int unsigned      DW   = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [DW-1:0]    LAST = DW'(DIV - 1);

    logic [DW-1:0] cnt_q, cnt_d;
    logic          tick_q, tick_d;

    always_comb begin
        cnt_d  = cnt_q;
        tick_d = tick_q;
        if (resync) begin
            cnt_d  = '0;
            tick_d = 1'b0;
        end else if (en) begin
            cnt_d  = (cnt_q == LAST) ? '0 : cnt_q + DW'(1);
            tick_d = (cnt_d == LAST);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q  <= '0;
            tick_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            tick_q <= tick_d;
        end
    end

    // The registered strobe is held across en=0 so it resumes on the right count;
    // gating with en keeps the strobe low while timing is paused.
    assign p_tick = tick_q & en;

endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster timing: pixel/line counters, sync, blanking and start-of-line/frame strobes.
// Define VGA_FRAME_CNT_EN to add the 16-bit frame_cnt output.
module vga_timing_gen
    import vga_timing_pkg::*;
#(
    parameter int unsigned DIV      = DEF_DIV,
    parameter int unsigned H_ACTIVE = DEF_H_ACTIVE,
    parameter int unsigned H_FP     = DEF_H_FP,
    parameter int unsigned H_SYNC   = DEF_H_SYNC,
    parameter int unsigned H_BP     = DEF_H_BP,
    parameter int unsigned V_ACTIVE = DEF_V_ACTIVE,
    parameter int unsigned V_FP     = DEF_V_FP,
    parameter int unsigned V_SYNC   = DEF_V_SYNC,
    parameter int unsigned V_BP     = DEF_V_BP,
    parameter bit          HS_POL   = 1'b0,
    parameter bit          VS_POL   = 1'b0,
    parameter int unsigned CW       = 10
) (
    input  logic          CLK,
    input  logic          RESET,
    input  logic          en,
    input  logic          resync,
    output logic          p_tick,
    output logic [CW-1:0] pixel_X,
    output logic [CW-1:0] pixel_Y,
    output logic          sincro_horiz,
    output logic          sincro_vert,
    output logic          video_on,
    output logic          line_start,
    output logic          frame_start
`ifdef VGA_FRAME_CNT_EN
    ,
    output logic [15:0]   frame_cnt
`endif
);

    localparam int unsigned H_TOTAL = h_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
    localparam int unsigned V_TOTAL = v_total(V_ACTIVE, V_FP, V_SYNC, V_BP);

    localparam logic [CW-1:0] H_LAST = CW'(H_TOTAL - 1);
    localparam logic [CW-1:0] V_LAST = CW'(V_TOTAL - 1);
    localparam logic [CW-1:0] H_VIS  = CW'(H_ACTIVE);
    localparam logic [CW-1:0] V_VIS  = CW'(V_ACTIVE);
    localparam logic [CW-1:0] HS_BEG = CW'(H_ACTIVE + H_FP);
    localparam logic [CW-1:0] HS_END = CW'(H_ACTIVE + H_FP + H_SYNC - 1);
    localparam logic [CW-1:0] VS_BEG = CW'(V_ACTIVE + V_FP);
    localparam logic [CW-1:0] VS_END = CW'(V_ACTIVE + V_FP + V_SYNC - 1);

    logic          tick;
    logic [CW-1:0] x_q, x_d;
    logic [CW-1:0] y_q, y_d;

    vga_tick_div #(
        .DIV (DIV)
    ) u_tick_div (
        .clk    (CLK),
        .reset  (RESET),
        .en     (en),
        .resync (resync),
        .p_tick (tick)
    );

    // resync wins over a coincident tick so the raster always restarts at the origin
    always_comb begin
        x_d = x_q;
        y_d = y_q;
        if (resync) begin
            x_d = '0;
            y_d = '0;
        end else if (tick) begin
            if (x_q == H_LAST) begin
                x_d = '0;
                y_d = (y_q == V_LAST) ? '0 : y_q + CW'(1);
            end else begin
                x_d = x_q + CW'(1);
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            x_q <= '0;
            y_q <= '0;
        end else begin
            x_q <= x_d;
            y_q <= y_d;
        end
    end

    // Sync and blanking decode the live counters directly so they never lag them.
    always_comb begin
        p_tick       = tick;
        pixel_X      = x_q;
        pixel_Y      = y_q;
        sincro_horiz = ((x_q >= HS_BEG) && (x_q <= HS_END)) ? HS_POL : ~HS_POL;
        sincro_vert  = ((y_q >= VS_BEG) && (y_q <= VS_END)) ? VS_POL : ~VS_POL;
        video_on     = (x_q < H_VIS) && (y_q < V_VIS);
        line_start   = tick && (x_q == '0);
        frame_start  = tick && (x_q == '0) && (y_q == '0);
    end

`ifdef VGA_FRAME_CNT_EN
    logic        frame_wrap;
    logic [15:0] fcnt_q;

    assign frame_wrap = tick && !resync && (x_q == H_LAST) && (y_q == V_LAST);

    always_ff @(posedge CLK) begin
        if (RESET) begin
            fcnt_q <= '0;
        end else if (frame_wrap) begin
            fcnt_q <= fcnt_q + 16'd1;
        end
    end

    assign frame_cnt = fcnt_q;
`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed self-checking bench for vga_timing_gen: default timing, DIV=1, a reduced raster
// for whole-frame checks, and the frame counter when VGA_FRAME_CNT_EN is defined.
module tb_vga_timing_gen;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_total = 0;
    int n_bad   = 0;

    logic a_done = 1'b0, b_done = 1'b0, c_done = 1'b0, d_done = 1'b0;

    // default instance (DIV=4, 640x480)
    logic       a_rst, a_en, a_rsy;
    logic       a_tick, a_hs, a_vs, a_vid, a_ls, a_fs;
    logic [9:0] a_x, a_y;
    // DIV=1, default geometry
    logic       b_rst, b_en, b_rsy;
    logic       b_tick, b_hs, b_vs, b_vid, b_ls, b_fs;
    logic [9:0] b_x, b_y;
    // reduced raster: H 8/2/3/3 (16), V 4/1/2/2 (9), DIV=4
    logic       c_rst, c_en, c_rsy;
    logic       c_tick, c_hs, c_vs, c_vid, c_ls, c_fs;
    logic [9:0] c_x, c_y;
`ifdef VGA_FRAME_CNT_EN
    logic [15:0] a_fc, b_fc, c_fc, d_fc;
    logic        d_rst, d_en, d_rsy;
    logic        d_tick, d_hs, d_vs, d_vid, d_ls, d_fs;
    logic [9:0]  d_x, d_y;
`endif

    vga_timing_gen u_def (
        .CLK(clk), .RESET(a_rst), .en(a_en), .resync(a_rsy), .p_tick(a_tick),
        .pixel_X(a_x), .pixel_Y(a_y), .sincro_horiz(a_hs), .sincro_vert(a_vs),
        .video_on(a_vid), .line_start(a_ls), .frame_start(a_fs)
`ifdef VGA_FRAME_CNT_EN
        , .frame_cnt(a_fc)
`endif
    );

    vga_timing_gen #(.DIV(1)) u_d1 (
        .CLK(clk), .RESET(b_rst), .en(b_en), .resync(b_rsy), .p_tick(b_tick),
        .pixel_X(b_x), .pixel_Y(b_y), .sincro_horiz(b_hs), .sincro_vert(b_vs),
        .video_on(b_vid), .line_start(b_ls), .frame_start(b_fs)
`ifdef VGA_FRAME_CNT_EN
        , .frame_cnt(b_fc)
`endif
    );

    vga_timing_gen #(
        .DIV(4), .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
        .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(2)
    ) u_small (
        .CLK(clk), .RESET(c_rst), .en(c_en), .resync(c_rsy), .p_tick(c_tick),
        .pixel_X(c_x), .pixel_Y(c_y), .sincro_horiz(c_hs), .sincro_vert(c_vs),
        .video_on(c_vid), .line_start(c_ls), .frame_start(c_fs)
`ifdef VGA_FRAME_CNT_EN
        , .frame_cnt(c_fc)
`endif
    );

`ifdef VGA_FRAME_CNT_EN
    vga_timing_gen #(
        .DIV(1), .H_ACTIVE(2), .H_FP(1), .H_SYNC(1), .H_BP(0),
        .V_ACTIVE(1), .V_FP(0), .V_SYNC(1), .V_BP(0)
    ) u_fcnt (
        .CLK(clk), .RESET(d_rst), .en(d_en), .resync(d_rsy), .p_tick(d_tick),
        .pixel_X(d_x), .pixel_Y(d_y), .sincro_horiz(d_hs), .sincro_vert(d_vs),
        .video_on(d_vid), .line_start(d_ls), .frame_start(d_fs), .frame_cnt(d_fc)
    );
`endif

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check_def_reset(input string tag);
        check_eq({tag, "_x"},   32'(a_x),   32'd0);
        check_eq({tag, "_y"},   32'(a_y),   32'd0);
        check_eq({tag, "_tick"}, 32'(a_tick), 32'd0);
        check_eq({tag, "_ls"},  32'(a_ls),  32'd0);
        check_eq({tag, "_fs"},  32'(a_fs),  32'd0);
        check_eq({tag, "_vid"}, 32'(a_vid), 32'd1);
        check_eq({tag, "_hs"},  32'(a_hs),  32'd1);
        check_eq({tag, "_vs"},  32'(a_vs),  32'd1);
    endtask

    initial begin : proc_def
        int lows, lines, ticks, moved;
        a_rst = 1'b1; a_en = 1'b0; a_rsy = 1'b0;
        step(3);
        check_def_reset("def_rst");
        a_rst = 1'b0; a_en = 1'b1;
        step(1); check_eq("def_tick_c1", 32'(a_tick), 32'd0);
        step(1); check_eq("def_tick_c2", 32'(a_tick), 32'd0);
        step(1); check_eq("def_first_tick", 32'(a_tick), 32'd1);
        check_eq("def_first_fs", 32'(a_fs), 32'd1);
        // cycle 0 is the first tick at the origin; x=k is held on cycles 4k-3..4k
        lows = 0; lines = 0;
        for (int c = 1; c <= 3200; c++) begin
            step(1);
            if (!a_hs) lows++;
            if (a_ls) lines++;
            if (c == 2556) check_eq("def_vid_x639", {a_x, a_vid}, {10'd639, 1'b1});
            if (c == 2557) check_eq("def_vid_x640", {a_x, a_vid}, {10'd640, 1'b0});
            if (c == 2620) check_eq("def_hs_x655", {a_x, a_hs}, {10'd655, 1'b1});
            if (c == 2621) check_eq("def_hs_x656", {a_x, a_hs}, {10'd656, 1'b0});
            if (c == 3004) check_eq("def_hs_x751", {a_x, a_hs}, {10'd751, 1'b0});
            if (c == 3005) check_eq("def_hs_x752", {a_x, a_hs}, {10'd752, 1'b1});
        end
        check_eq("def_hs_low_cycles", 32'(lows), 32'd384);
        check_eq("def_line_starts", 32'(lines), 32'd1);
        check_eq("def_line2_start", {a_ls, a_x, a_y}, {1'b1, 10'd0, 10'd1});

        for (int i = 0; i < 2000 && a_x != 10'd300; i++) step(1);
        check_eq("def_reach_300", 32'(a_x), 32'd300);
        a_en = 1'b0;
        ticks = 0; moved = 0;
        for (int i = 0; i < 100; i++) begin
            step(1);
            if (a_tick || a_ls || a_fs) ticks++;
            if (a_x != 10'd300) moved++;
        end
        check_eq("def_hold_ticks", 32'(ticks), 32'd0);
        check_eq("def_hold_moved", 32'(moved), 32'd0);
        check_eq("def_hold_xy", {a_x, a_y}, {10'd300, 10'd1});
        a_en = 1'b1;
        for (int i = 0; i < 10 && a_x == 10'd300; i++) step(1);
        check_eq("def_resume", {a_x, a_y}, {10'd301, 10'd1});

        for (int i = 0; i < 4000 && a_x != 10'd700; i++) step(1);
        check_eq("def_in_sync", {a_x, a_hs}, {10'd700, 1'b0});
        a_rst = 1'b1;
        step(1); check_def_reset("def_midrst");
        step(1);
        a_rst = 1'b0;
        step(1); check_eq("def_rel_c1", 32'(a_tick), 32'd0);
        step(1); check_eq("def_rel_c2", 32'(a_tick), 32'd0);
        step(1); check_eq("def_rel_fs", {a_tick, a_fs}, {1'b1, 1'b1});
        a_done = 1'b1;
    end

    initial begin : proc_d1
        int gaps, lines;
        b_rst = 1'b1; b_en = 1'b0; b_rsy = 1'b0;
        step(3);
        b_rst = 1'b0; b_en = 1'b1;
        check_eq("d1_tick_first_cycle", 32'(b_tick), 32'd0);
        step(1); check_eq("d1_first_fs", {b_tick, b_fs}, {1'b1, 1'b1});
        gaps = 0; lines = 0;
        for (int c = 1; c <= 800; c++) begin
            step(1);
            if (!b_tick) gaps++;
            if (b_ls) lines++;
        end
        check_eq("d1_tick_gaps", 32'(gaps), 32'd0);
        check_eq("d1_line_starts", 32'(lines), 32'd1);
        check_eq("d1_line800", {b_ls, b_x, b_y}, {1'b1, 10'd0, 10'd1});

        for (int i = 0; i < 200000 && !(b_x == 10'd700 && b_y == 10'd200); i++) step(1);
        check_eq("d1_at_700_200", {b_tick, b_x, b_y, b_hs}, {1'b1, 10'd700, 10'd200, 1'b0});
        b_rsy = 1'b1;
        step(1);
        b_rsy = 1'b0;
        check_eq("d1_resync_xy", {b_x, b_y}, {10'd0, 10'd0});
        check_eq("d1_resync_sync", {b_hs, b_vs, b_vid}, {1'b1, 1'b1, 1'b1});
        check_eq("d1_resync_tick", 32'(b_tick), 32'd0);
        step(1); check_eq("d1_resync_fs", {b_tick, b_fs}, {1'b1, 1'b1});
        b_done = 1'b1;
    end

    initial begin : proc_small
        int flen, vlows, hlows;
        logic [15:0] vs_seen;
        c_rst = 1'b1; c_en = 1'b0; c_rsy = 1'b0;
        step(3);
        c_rst = 1'b0; c_en = 1'b1;
        step(3);
        check_eq("sm_first_fs", {c_fs, c_tick, c_vid, c_x}, {1'b1, 1'b1, 1'b1, 10'd0});
        flen = 0; vlows = 0; hlows = 0; vs_seen = '0;
        for (int c = 1; c <= 700 && flen == 0; c++) begin
            step(1);
            if (c_fs) begin
                flen = c;
            end else begin
                if (!c_vs) vlows++;
                if (!c_hs) hlows++;
                if (c_ls) vs_seen[c_y[3:0]] = c_vs;
            end
        end
        check_eq("sm_frame_period", 32'(flen), 32'd576);
        check_eq("sm_frame_origin", {c_x, c_y}, {10'd0, 10'd0});
        check_eq("sm_vs_low_cycles", 32'(vlows), 32'd128);
        check_eq("sm_hs_low_cycles", 32'(hlows), 32'd108);
        check_eq("sm_vs_by_line", 32'(vs_seen[7:4]), 32'b1001);
        c_done = 1'b1;
    end

`ifdef VGA_FRAME_CNT_EN
    initial begin : proc_fcnt
        d_rst = 1'b1; d_en = 1'b0; d_rsy = 1'b0;
        step(2);
        check_eq("fc_reset", 32'(d_fc), 32'd0);
        d_rst = 1'b0; d_en = 1'b1;
        for (int i = 0; i < 600000 && d_fc != 16'hFFFF; i++) step(1);
        check_eq("fc_reach_ffff", 32'(d_fc), 32'hFFFF);
        d_rsy = 1'b1;
        step(1);
        d_rsy = 1'b0;
        check_eq("fc_resync_keeps", 32'(d_fc), 32'hFFFF);
        for (int i = 0; i < 20 && d_fc == 16'hFFFF; i++) step(1);
        check_eq("fc_wrap_zero", 32'(d_fc), 32'd0);
        for (int i = 0; i < 20 && d_fc == 16'd0; i++) step(1);
        check_eq("fc_then_one", 32'(d_fc), 32'd1);
        d_done = 1'b1;
    end

    initial begin : proc_watchdog
        #12000000;
        $display("FAIL watchdog: run did not complete, got timeout expected finish");
        $fatal(1, "watchdog");
    end
`else
    initial d_done = 1'b1;

    initial begin : proc_watchdog
        #4000000;
        $display("FAIL watchdog: run did not complete, got timeout expected finish");
        $fatal(1, "watchdog");
    end
`endif

    initial begin : proc_summary
        wait (a_done && b_done && c_done && d_done);
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

// File: doc/vga_timing_gen.md
VGA_TIMING_GEN -- requirements
Module: vga_timing_gen

Interface
REQ-001 The block SHALL have parameter DIV, default 4, giving CLK cycles per pixel (legal range >= 1).
REQ-002 The block SHALL have parameter H_ACTIVE, default 640, giving visible pixels per line.
REQ-003 The block SHALL have parameter H_FP, default 16, giving horizontal front porch in pixels.
REQ-004 The block SHALL have parameter H_SYNC, default 96, giving horizontal sync width in pixels.
REQ-005 The block SHALL have parameter H_BP, default 48, giving horizontal back porch in pixels.
REQ-006 The block SHALL have parameters V_ACTIVE, V_FP, V_SYNC, V_BP, defaults 480, 10, 2, 33, giving the vertical equivalents in lines.
REQ-007 The block SHALL have parameters HS_POL and VS_POL, default 0 each, giving the asserted sync level (0 = active-low).
REQ-008 The block SHALL have parameter CW, default 10, giving the pixel_X/pixel_Y width; CW SHALL hold H_TOTAL-1 and V_TOTAL-1.
REQ-009 Port CLK, input, 1 bit: single system clock; every register SHALL be clocked on its rising edge.
REQ-010 Port RESET, input, 1 bit: synchronous, active-high reset.
REQ-011 Port en, input, 1 bit: timing advances only while en is high.
REQ-012 Port resync, input, 1 bit: one-cycle request to restart the frame from the origin.
REQ-013 Port p_tick, output, 1 bit: pixel-rate strobe, one CLK wide.
REQ-014 Ports pixel_X and pixel_Y, outputs, CW bits each: current column and row counters.
REQ-015 Ports sincro_horiz and sincro_vert, outputs, 1 bit each: horizontal and vertical sync.
REQ-016 Port video_on, output, 1 bit: high while the counters are inside the active area.
REQ-017 Ports line_start and frame_start, outputs, 1 bit each: one-CLK pulses marking the start of a line and of a frame.

Function
REQ-018 H_TOTAL SHALL equal H_ACTIVE+H_FP+H_SYNC+H_BP, and V_TOTAL SHALL equal V_ACTIVE+V_FP+V_SYNC+V_BP.
REQ-019 The divider counter SHALL count 0..DIV-1 only while en=1, and p_tick SHALL be a registered signal that is high for exactly the one CLK cycle in which the divider counter holds DIV-1 and en=1.
REQ-020 With DIV=1 and en=1, p_tick SHALL be high on every cycle after the first post-reset cycle.
REQ-021 On a CLK edge where p_tick=1, pixel_X SHALL increment; at H_TOTAL-1 it SHALL wrap to 0 and pixel_Y SHALL increment; pixel_Y at V_TOTAL-1 SHALL wrap to 0 in the same cycle.
REQ-022 sincro_horiz SHALL equal HS_POL when pixel_X is in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC-1] and SHALL equal ~HS_POL otherwise.
REQ-023 sincro_vert SHALL follow the same rule as REQ-022 on pixel_Y using V_ACTIVE, V_FP, V_SYNC and VS_POL.
REQ-024 Both sync outputs SHALL be aligned with the counter values they decode, with zero lag.
REQ-025 video_on SHALL equal (pixel_X < H_ACTIVE) AND (pixel_Y < V_ACTIVE).
REQ-026 line_start SHALL equal p_tick AND (pixel_X == 0), and frame_start SHALL equal line_start AND (pixel_Y == 0).
REQ-027 With en=0, the divider, counters and syncs SHALL hold their values and p_tick, line_start and frame_start SHALL be 0.
REQ-028 resync=1 SHALL clear the divider, pixel_X, pixel_Y and p_tick on the next edge, regardless of en or a coincident p_tick.
REQ-029 RESET SHALL take priority over resync, and resync SHALL take priority over en.

Reset
REQ-030 While RESET is sampled high: divider = 0, pixel_X = 0, pixel_Y = 0, p_tick = 0, line_start = 0, frame_start = 0.
REQ-031 While RESET is sampled high, video_on SHALL be 1, sincro_horiz SHALL be ~HS_POL and sincro_vert SHALL be ~VS_POL.
REQ-032 The first frame_start after reset release SHALL coincide with the first p_tick.
REQ-033 RESET asserted mid-frame SHALL abort the frame; no partial sync pulse SHALL persist past the reset edge.

Configuration
REQ-034 When macro VGA_FRAME_CNT_EN is defined, the block SHALL add output port frame_cnt[15:0], reset to 0.
REQ-035 frame_cnt SHALL increment on the edge where pixel_Y wraps V_TOTAL-1 -> 0, SHALL wrap 0xFFFF -> 0, and SHALL NOT be altered by resync.
REQ-036 When VGA_FRAME_CNT_EN is undefined, the frame_cnt port and its logic SHALL be absent.

Structure
REQ-037 Package vga_timing_pkg SHALL hold the 640x480@60 timing constants and the H_TOTAL/V_TOTAL derivation functions.
REQ-038 The divider, including its en, resync and RESET handling, SHALL be a separate sub-module named vga_tick_div.

Verification
REQ-039 Bench SHALL cover defaults with en=1: frame period = 800*525*4 = 1,680,000 CLK; sincro_horiz low for pixel_X 656..751; sincro_vert low for pixel_Y 490..491.
REQ-040 Bench SHALL cover DIV=1: p_tick high continuously; line_start every 800 CLK.
REQ-041 Bench SHALL cover en=0 for 100 CLK at pixel_X=300: counters hold at 300; no p_tick; resume at 301.
REQ-042 Bench SHALL cover resync at pixel_X=700, pixel_Y=200, coincident with p_tick: next cycle both counters are 0 and syncs are deasserted.
REQ-043 Bench SHALL cover RESET mid-sync, then release: all outputs match REQ-030/REQ-031; first p_tick DIV cycles later asserts frame_start.
REQ-044 Bench SHALL cover VGA_FRAME_CNT_EN with H_TOTAL=4 and V_TOTAL=2 over 65,537 frames: frame_cnt reaches 0xFFFF, then reads 1.
